seg_capture: RTL and testbench
==============================

# seg_capture

- Recovers the 4-digit hex value shown on a multiplexed, active-low 7-segment display bus, the reverse of the binary-to-segment decoder path.
- Synchronizes and debounces the segment/anode bus, then maps each stable segment pattern back to a 4-bit nibble.
- Assembles a 16-bit word once all four digit positions have been captured.
- Sits on the FPGA board-test side, monitoring display drivers in loopback.

## Interface
- STABLE_CYCLES, 4, consecutive identical synchronized samples required before a pattern is captured; legal range 1..255.
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous assert, active-low.
- seg_n  input  7  segment bus, active-low (0 = lit); bit0..bit6 = segments a..g.
- an_n  input  4  digit enables, active-low; an_n[k] low selects digit k (k=0 is least significant nibble).
- value  output  16  last completed frame; value[4k+3:4k] = digit k.
- digit_err  output  4  per-digit flag for the last frame: pattern was not a legal hex glyph.
- frame_valid  output  1  one-cycle pulse; value/digit_err updated on the same edge.
- scan_err  output  1  one-cycle pulse; a stable window had more than one an_n bit low.

## Operation
- Input stage: {an_n, seg_n} pass through the synchronizer (see Configuration); result is s, latency L.
- Change detector: register s_q holds the previous s; cnt is an 8-bit saturating counter.
  - Edge with s != s_q: cnt <= 1, s_q <= s, FSM -> TRACK.
  - Edge with s == s_q and cnt < STABLE_CYCLES: cnt increments.
- FSM states:
  - TRACK: counting. On the edge where cnt reaches STABLE_CYCLES, evaluate the window, then go to HELD.
  - HELD: no further capture until s changes, which returns the FSM to TRACK. A digit held forever is captured exactly once.
- Window evaluation:
  - an_n all-high (blank): ignored, no flag.
  - More than one an_n bit low: scan_err pulse; nothing captured.
  - Exactly one bit k low: decode seg_n into slot k, set seen[k].
- Decode table, active-low seg_n as hex, digits 0..F: 40,79,24,30,19,12,02,78,00,10,08,03,46,21,06,0E.
  - Any other pattern: nibble 0, err[k] = 1.
- A re-capture of slot k before the frame completes overwrites the nibble and err bit and does not double-count.
- Frame completion: the capture edge on which (seen | bit k) == 4'hF does the following.
  - value <= merged slots including the new digit.
  - digit_err <= merged err bits.
  - frame_valid <= 1 and seen <= 0.
- value and digit_err hold until the next frame completes.
- STABLE_CYCLES = 1: capture occurs on the change-detect edge itself.

## Timing
- Reset values: value = 16'h0000, digit_err = 4'h0, frame_valid = 0, scan_err = 0.
- Internal reset values: seen = 0, slots = 0, cnt = 0, s_q = 7'h7F/4'hF (blank), FSM = HELD.
- Edge 0 is the first edge sampling a new bus value. The capture edge is edge L+STABLE_CYCLES-1.
  - Default: L = 2, STABLE_CYCLES = 4, capture on edge 5.
- frame_valid and scan_err are single-cycle pulses, high in the cycle after the capture edge.
- Any bus change before cnt reaches STABLE_CYCLES restarts the count; a glitch of fewer than STABLE_CYCLES samples is never captured.
- rst_n low mid-frame: all state clears immediately; a partially seen frame is discarded.
- rst_n deassertion is not synchronized internally; the system reset tree supplies a synchronized release.

## Configuration
- SEG_CAPTURE_SYNC_EN defined: each bus bit passes through a 2-flop synchronizer, L = 2. Use this when the display bus comes from another clock domain or from pins.
- SEG_CAPTURE_SYNC_EN undefined: a single input register, L = 1. Use this only for same-clock loopback.
- Macro state changes no other behaviour.

## Test plan
- Reset: hold rst_n low with random bus activity -> value = 0000, digit_err = 0, no pulses. Release, then drive blank for 20 cycles -> no pulses.
- Frame 0xA5C3, default config: drive an_n = E/D/B/7 with seg_n = 30/46/12/08, each for 6 cycles.
  - frame_valid pulses once, on the cycle after edge 5 of the an_n = 7 window.
  - value = A5C3, digit_err = 0.
- Debounce: inside a digit window, toggle seg_n for 3 cycles (STABLE_CYCLES = 4) -> toggled pattern not captured; final stable pattern captured once.
- Invalid glyph: digit 2 driven with seg_n = 7F, others 00 -> value = 8088, digit_err = 4'b0100.
- Ghosting: an_n = C (two bits low) stable for 8 cycles -> scan_err single pulse, seen unchanged, no frame_valid.
- Reset mid-frame: capture digits 0 and 1, pulse rst_n low, then capture digits 2 and 3 -> no frame_valid until digits 0 and 1 are recaptured.
- Repeat the second scenario without SEG_CAPTURE_SYNC_EN -> capture one edge earlier.

Source files
------------

// File: rtl/seg_capture_if.sv
// seg_capture_if: multiplexed 7-segment display bus (active-low) plus recovered-frame outputs.
interface seg_capture_if;
    logic [6:0]  seg_n;
    logic [3:0]  an_n;
    logic [15:0] value;
    logic [3:0]  digit_err;
    logic        frame_valid;
    logic        scan_err;
    modport master (output seg_n, an_n, input value, digit_err, frame_valid, scan_err);
    modport slave  (input seg_n, an_n, output value, digit_err, frame_valid, scan_err);
endinterface

// File: rtl/seg_capture.sv
// seg_capture: debounces a multiplexed active-low 7-segment bus and recovers the 4-digit hex word.
// SEG_CAPTURE_SYNC_EN selects a 2-flop input synchronizer (latency 2) instead of a single register.
module seg_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input logic         clk,
    input logic         rst_n,
    seg_capture_if.slave bus
);
    typedef enum logic {TRACK, HELD} state_t;
    localparam logic [10:0] BLANK = 11'h7FF;
    localparam logic [6:0] GLYPH [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                          7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

    logic [10:0] s, s_q;
    logic [7:0]  cnt_q, cnt_d;
    state_t      state_q, state_d;
    logic [15:0] slots_q, slots_d, value_q, value_d;
    logic [3:0]  errs_q, errs_d, err_q, err_d, seen_q, seen_d;
    logic        fv_q, fv_d, scan_q, scan_d;
    logic        changed, reach, multi, capture, done, bad;
    logic [3:0]  sel, nib, seen_m;
    logic [15:0] mask, slots_m;
    logic [3:0]  errs_m;

`ifdef SEG_CAPTURE_SYNC_EN
    logic [10:0] sync1_q, sync2_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            sync1_q <= BLANK;
            sync2_q <= BLANK;
        end else begin
            sync1_q <= {bus.an_n, bus.seg_n};
            sync2_q <= sync1_q;
        end
    assign s = sync2_q;
`else
    logic [10:0] sync1_q;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) sync1_q <= BLANK;
        else        sync1_q <= {bus.an_n, bus.seg_n};
    assign s = sync1_q;
`endif

    always_comb begin
        nib = 4'h0;
        bad = 1'b1;
        for (int i = 0; i < 16; i++)
            if (s[6:0] == GLYPH[i]) begin
                nib = 4'(i);
                bad = 1'b0;
            end
    end

    // A window is evaluated only on the edge where the count first reaches STABLE_CYCLES.
    always_comb begin
        changed = s != s_q;
        cnt_d   = changed ? 8'd1 : (cnt_q < STABLE ? cnt_q + 8'd1 : cnt_q);
        reach   = (cnt_d == STABLE) && (changed || state_q == TRACK);
        state_d = reach ? HELD : (changed ? TRACK : state_q);
        sel     = ~s[10:7];
        multi   = (sel & (sel - 4'd1)) != 4'd0;
        capture = reach && !multi && sel != 4'd0;
        scan_d  = reach && multi;
        mask    = {{4{sel[3]}}, {4{sel[2]}}, {4{sel[1]}}, {4{sel[0]}}};
        slots_m = (slots_q & ~mask) | ({4{nib}} & mask);
        errs_m  = (errs_q & ~sel) | (sel & {4{bad}});
        seen_m  = seen_q | sel;
        done    = capture && seen_m == 4'hF;
        slots_d = capture ? slots_m : slots_q;
        errs_d  = capture ? errs_m : errs_q;
        seen_d  = done ? 4'h0 : (capture ? seen_m : seen_q);
        value_d = done ? slots_m : value_q;
        err_d   = done ? errs_m : err_q;
        fv_d    = done;
    end

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            s_q     <= BLANK;
            cnt_q   <= 8'd0;
            state_q <= HELD;
            slots_q <= 16'h0;
            errs_q  <= 4'h0;
            seen_q  <= 4'h0;
            value_q <= 16'h0;
            err_q   <= 4'h0;
            fv_q    <= 1'b0;
            scan_q  <= 1'b0;
        end else begin
            s_q     <= s;
            cnt_q   <= cnt_d;
            state_q <= state_d;
            slots_q <= slots_d;
            errs_q  <= errs_d;
            seen_q  <= seen_d;
            value_q <= value_d;
            err_q   <= err_d;
            fv_q    <= fv_d;
            scan_q  <= scan_d;
        end

    assign bus.value       = value_q;
    assign bus.digit_err   = err_q;
    assign bus.frame_valid = fv_q;
    assign bus.scan_err    = scan_q;
endmodule

// File: tb/tb_seg_capture.sv
// tb_seg_capture: directed stimulus with a scoreboard of expected frames/scan errors and their cycles.
module tb_seg_capture;
    localparam int S = 4;
`ifdef SEG_CAPTURE_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 1;
`endif

    typedef struct {
        logic [15:0] v;
        logic [3:0]  e;
        int          c;
    } fr_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    fr_t  fq[$];
    int   sq[$];

    seg_capture_if bus ();
    seg_capture #(.STABLE_CYCLES(S)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Hold a bus pattern for n sampling edges; optionally expect a frame or scan error from it.
    task automatic put(input logic [3:0] an, input logic [6:0] seg, input int n,
                       input bit fr, input logic [15:0] v, input logic [3:0] e, input bit sc);
        @(negedge clk);
        bus.an_n  = an;
        bus.seg_n = seg;
        if (fr) fq.push_back('{v, e, cyc + L + S});
        if (sc) sq.push_back(cyc + L + S);
        repeat (n - 1) @(negedge clk);
    endtask

    always @(negedge clk) begin : monitor
        fr_t f;
        int  c;
        if (bus.frame_valid === 1'b1) begin
            if (fq.size() == 0) chk("unexpected frame_valid", 1, 0);
            else begin
                f = fq.pop_front();
                chk("value", 32'(bus.value), 32'(f.v));
                chk("digit_err", 32'(bus.digit_err), 32'(f.e));
                chk("frame cycle", cyc, f.c);
            end
        end
        if (bus.scan_err === 1'b1) begin
            if (sq.size() == 0) chk("unexpected scan_err", 1, 0);
            else begin
                c = sq.pop_front();
                chk("scan cycle", cyc, c);
            end
        end
    end

    initial begin
        bus.an_n  = 4'hF;
        bus.seg_n = 7'h7F;
        repeat (10) begin
            @(negedge clk);
            bus.an_n  = 4'($urandom);
            bus.seg_n = 7'($urandom);
            chk("reset outputs", {bus.value, bus.digit_err, bus.frame_valid, bus.scan_err}, 0);
        end
        @(negedge clk);
        bus.an_n  = 4'hF;
        bus.seg_n = 7'h7F;
        rst_n     = 1'b1;
        repeat (20) @(negedge clk);
        // 0xA5C3
        put(4'hE, 7'h30, 6, 0, 0, 0, 0);
        put(4'hD, 7'h46, 6, 0, 0, 0, 0);
        put(4'hB, 7'h12, 6, 0, 0, 0, 0);
        put(4'h7, 7'h08, 6, 1, 16'hA5C3, 4'h0, 0);
        put(4'hF, 7'h7F, 20, 0, 0, 0, 0);
        // short glitches inside digit 0, then a long hold of the last digit
        put(4'hE, 7'h79, 2, 0, 0, 0, 0);
        put(4'hE, 7'h24, 1, 0, 0, 0, 0);
        put(4'hE, 7'h79, 1, 0, 0, 0, 0);
        put(4'hE, 7'h24, 1, 0, 0, 0, 0);
        put(4'hE, 7'h19, 6, 0, 0, 0, 0);
        put(4'hD, 7'h02, 6, 0, 0, 0, 0);
        put(4'hB, 7'h78, 6, 0, 0, 0, 0);
        put(4'h7, 7'h00, 30, 1, 16'h8764, 4'h0, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        // digit 0 overwritten, digit 2 illegal glyph
        put(4'hE, 7'h40, 6, 0, 0, 0, 0);
        put(4'hE, 7'h00, 6, 0, 0, 0, 0);
        put(4'hD, 7'h00, 6, 0, 0, 0, 0);
        put(4'hB, 7'h7F, 6, 0, 0, 0, 0);
        put(4'h7, 7'h00, 6, 1, 16'h8088, 4'b0100, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        // ghosting on digits 0/1 must not mark them seen
        put(4'hC, 7'h40, 8, 0, 0, 0, 1);
        put(4'hB, 7'h21, 6, 0, 0, 0, 0);
        put(4'h7, 7'h03, 6, 0, 0, 0, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        put(4'hE, 7'h0E, 6, 0, 0, 0, 0);
        put(4'hD, 7'h10, 6, 1, 16'hBD9F, 4'h0, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        // reset mid-frame discards digits 0 and 1
        put(4'hE, 7'h79, 6, 0, 0, 0, 0);
        put(4'hD, 7'h24, 6, 0, 0, 0, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        chk("mid reset value", 32'(bus.value), 0);
        chk("mid reset digit_err", 32'(bus.digit_err), 0);
        rst_n = 1'b1;
        put(4'hB, 7'h06, 6, 0, 0, 0, 0);
        put(4'h7, 7'h0E, 6, 0, 0, 0, 0);
        put(4'hF, 7'h7F, 6, 0, 0, 0, 0);
        put(4'hE, 7'h79, 6, 0, 0, 0, 0);
        put(4'hD, 7'h24, 6, 1, 16'hFE21, 4'h0, 0);
        put(4'hF, 7'h7F, 10, 0, 0, 0, 0);
        chk("frames outstanding", fq.size(), 0);
        chk("scan errors outstanding", sq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
